// File: rtl/edge_acc_param.sv
// Sobel-magnitude / binary-threshold edge filter over a packed 8-bit image held in word memory.
// Each interior output word takes 4 cycles: three window reads, then one write.
module edge_acc_param #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int OUT_BASE = IMG_W / 4 * IMG_H
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] addr,
  input  logic [31:0] dataR,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  thresh,
  output logic        finish
);
  localparam int          WPR   = IMG_W / 4;
  localparam logic [15:0] WPR1  = 16'(WPR);
  localparam logic [15:0] WPR2  = 16'(2 * WPR);
  localparam logic [15:0] WLAST = 16'(WPR - 1);
  localparam logic [15:0] YLAST = 16'(IMG_H - 2);
  localparam logic [15:0] OBASE = 16'(OUT_BASE);
  localparam logic [15:0] OBOT  = 16'(OUT_BASE + (IMG_H - 1) * WPR);

  typedef enum logic [2:0] {IDLE, TOP, PRIME, PROC, BOTTOM, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ph;
  logic [15:0] r_col;
  logic [15:0] r_y;
  logic [15:0] r_rowbase;
  logic        r_mode;
  logic [7:0]  r_thresh;

  logic [31:0] r_cur [3];
  logic [31:0] r_nxt [2];
  logic [7:0]  r_prv [3];

  logic [15:0] w_rowoff;
  logic [47:0] w_win [3];
  logic [31:0] w_pix;

  function automatic logic [11:0] sobel_mag(input logic [23:0] t, input logic [23:0] m,
                                            input logic [23:0] b);
    logic signed [11:0] s11, s12, s13, s21, s23, s31, s32, s33;
    logic signed [11:0] dx, dy, adx, ady;
    s11 = $signed({4'd0, t[7:0]});
    s12 = $signed({4'd0, t[15:8]});
    s13 = $signed({4'd0, t[23:16]});
    s21 = $signed({4'd0, m[7:0]});
    s23 = $signed({4'd0, m[23:16]});
    s31 = $signed({4'd0, b[7:0]});
    s32 = $signed({4'd0, b[15:8]});
    s33 = $signed({4'd0, b[23:16]});
    dx  = (s13 + (s23 <<< 1) + s33) - (s11 + (s21 <<< 1) + s31);
    dy  = (s11 + (s12 <<< 1) + s13) - (s31 + (s32 <<< 1) + s33);
    adx = dx[11] ? -dx : dx;
    ady = dy[11] ? -dy : dy;
    return $unsigned(adx) + $unsigned(ady);
  endfunction

  function automatic logic [7:0] out_pix(input logic [11:0] mag, input logic md,
                                         input logic [7:0] th);
    if (md) return (mag >= {4'd0, th}) ? 8'hFF : 8'h00;
    return (mag > 12'd255) ? 8'hFF : mag[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph      <= 2'd0;
      r_col     <= 16'd0;
      r_y       <= 16'd0;
      r_rowbase <= 16'd0;
      r_mode    <= 1'b0;
      r_thresh  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_mode    <= mode;
          r_thresh  <= thresh;
          r_ph      <= 2'd0;
          r_col     <= 16'd0;
          r_y       <= 16'd1;
          r_rowbase <= 16'd0;
        end
        TOP, BOTTOM: r_col <= (r_col == WLAST) ? 16'd0 : r_col + 16'd1;
        PRIME: r_ph <= r_ph + 2'd1;
        PROC: begin
          r_ph <= r_ph + 2'd1;
          if (r_ph == 2'd3) begin
            if (r_col == WLAST) begin
              r_col     <= 16'd0;
              r_y       <= r_y + 16'd1;
              r_rowbase <= r_rowbase + WPR1;
            end else begin
              r_col <= r_col + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Window capture: rows y-1, y, y+1 arrive one cycle after their read request
  always_ff @(posedge clk) begin
    if (r_state == PRIME) begin
      case (r_ph)
        2'd1:    r_cur[0] <= dataR;
        2'd2:    r_cur[1] <= dataR;
        2'd3:    r_cur[2] <= dataR;
        default: ;
      endcase
    end else if (r_state == PROC) begin
      case (r_ph)
        2'd1: r_nxt[0] <= dataR;
        2'd2: r_nxt[1] <= dataR;
        2'd3: begin
          for (int r = 0; r < 3; r++) r_prv[r] <= r_cur[r][31:24];
          r_cur[0] <= r_nxt[0];
          r_cur[1] <= r_nxt[1];
          r_cur[2] <= dataR;
        end
        default: ;
      endcase
    end
  end

  // Six-pixel strip per row: left neighbour byte, current word, right neighbour byte
  assign w_win[0] = {r_nxt[0][7:0], r_cur[0], r_prv[0]};
  assign w_win[1] = {r_nxt[1][7:0], r_cur[1], r_prv[1]};
  assign w_win[2] = {dataR[7:0],    r_cur[2], r_prv[2]};

  assign w_rowoff = (r_ph == 2'd0) ? 16'd0 : (r_ph == 2'd1) ? WPR1 : WPR2;

  always_comb begin
    w_pix = '0;
    for (int j = 0; j < 4; j++) begin
      w_pix[8*j +: 8] = out_pix(sobel_mag(w_win[0][8*j +: 24], w_win[1][8*j +: 24],
                                          w_win[2][8*j +: 24]), r_mode, r_thresh);
    end
    if (r_col == 16'd0) w_pix[7:0]   = 8'd0;
    if (r_col == WLAST) w_pix[31:24] = 8'd0;
  end

  always_comb begin
    w_state_nxt = r_state;
    addr        = '0;
    dataW       = '0;
    en          = 1'b0;
    we          = 1'b0;
    finish      = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = TOP;
      TOP: begin
        en   = 1'b1;
        we   = 1'b1;
        addr = OBASE + r_col;
        if (r_col == WLAST) w_state_nxt = PRIME;
      end
      PRIME: begin
        if (r_ph != 2'd3) begin
          en   = 1'b1;
          addr = r_rowbase + w_rowoff;
        end else begin
          w_state_nxt = PROC;
        end
      end
      PROC: begin
        if (r_ph != 2'd3) begin
          if (r_col != WLAST) begin
            en   = 1'b1;
            addr = r_rowbase + w_rowoff + r_col + 16'd1;
          end
        end else begin
          en    = 1'b1;
          we    = 1'b1;
          addr  = OBASE + r_rowbase + WPR1 + r_col;
          dataW = w_pix;
          if (r_col == WLAST) w_state_nxt = (r_y == YLAST) ? BOTTOM : PRIME;
        end
      end
      BOTTOM: begin
        en   = 1'b1;
        we   = 1'b1;
        addr = OBOT + r_col;
        if (r_col == WLAST) w_state_nxt = DONE;
      end
      DONE: begin
        finish = 1'b1;
        if (!start) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_edge_acc_param.sv
// Bench for edge_acc_param: a tiny 8x3 instance and a 32x12 instance share one memory model.
`timescale 1ns/1ps
module tb_edge_acc_param;
  localparam int SM_W = 8,  SM_H = 3,  SM_N = SM_W / 4 * SM_H;
  localparam int MD_W = 32, MD_H = 12, MD_N = MD_W / 4 * MD_H;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, sel = 1'b0;
  logic [7:0]  thresh = 8'd0;
  logic [31:0] dataR;
  logic [15:0] addr_sm, addr_md, addr_m;
  logic [31:0] dataW_sm, dataW_md, dataW_m;
  logic        en_sm, en_md, we_sm, we_md, fin_sm, fin_md, en_m, we_m, fin_m;
  logic [31:0] mem [0:255];
  logic [47:0] obs_q [$];
  logic [47:0] exp_q [$];
  int          in_n;
  int          acc_cnt = 0, viol = 0, total = 0, bad = 0;

  always #5 clk = ~clk;

  edge_acc_param #(.IMG_W(SM_W), .IMG_H(SM_H)) u_sm (
    .clk(clk), .reset(reset), .addr(addr_sm), .dataR(dataR), .dataW(dataW_sm),
    .en(en_sm), .we(we_sm), .start(start & ~sel), .mode(mode), .thresh(thresh),
    .finish(fin_sm));

  edge_acc_param #(.IMG_W(MD_W), .IMG_H(MD_H)) u_md (
    .clk(clk), .reset(reset), .addr(addr_md), .dataR(dataR), .dataW(dataW_md),
    .en(en_md), .we(we_md), .start(start & sel), .mode(mode), .thresh(thresh),
    .finish(fin_md));

  assign addr_m  = sel ? addr_md  : addr_sm;
  assign dataW_m = sel ? dataW_md : dataW_sm;
  assign en_m    = sel ? en_md    : en_sm;
  assign we_m    = sel ? we_md    : we_sm;
  assign fin_m   = sel ? fin_md   : fin_sm;
  always_comb in_n = sel ? MD_N : SM_N;

  always @(posedge clk) dataR <= mem[addr_m[7:0]];

  // Memory-side monitor: logs every write and flags illegal accesses
  always @(negedge clk) begin
    if (en_m && we_m) obs_q.push_back({addr_m, dataW_m});
    if (en_m) acc_cnt <= acc_cnt + 1;
    if ((we_m && !en_m) ||
        (en_m && !we_m && int'(addr_m) >= in_n) ||
        (en_m && we_m && (int'(addr_m) < in_n || int'(addr_m) >= 2 * in_n)))
      viol <= viol + 1;
  end

  function automatic int bnd(input int w, input int h);
    return 4 * (w / 4) * (h - 2) + 2 * (w / 4) + 4 * h + 8;
  endfunction

  function automatic int pix(input int x, input int y, input int wpr);
    logic [31:0] wv;
    wv = mem[y * wpr + x / 4];
    return int'(wv[8 * (x % 4) +: 8]);
  endfunction

  task automatic build_exp(input int w, input int h, input logic md, input int th);
    int wpr, dx, dy, mag, v, x;
    int s [3][3];
    logic [31:0] word;
    wpr = w / 4;
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int k = 0; k < wpr; k++) begin
        word = '0;
        for (int j = 0; j < 4; j++) begin
          x = 4 * k + j;
          if (y > 0 && y < h - 1 && x > 0 && x < w - 1) begin
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++) s[r][c] = pix(x + c - 1, y + r - 1, wpr);
            dx  = (s[0][2] + 2 * s[1][2] + s[2][2]) - (s[0][0] + 2 * s[1][0] + s[2][0]);
            dy  = (s[0][0] + 2 * s[0][1] + s[0][2]) - (s[2][0] + 2 * s[2][1] + s[2][2]);
            mag = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
            v   = md ? ((mag >= th) ? 255 : 0) : ((mag > 255) ? 255 : mag);
            word[8 * j +: 8] = 8'(v);
          end
        end
        exp_q.push_back({16'(wpr * h + y * wpr + k), word});
      end
    end
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = $urandom;
  endtask

  task automatic do_run(input logic md, input logic [7:0] th, output int cyc);
    @(negedge clk); start = 1'b1; mode = md;  thresh = th;
    @(negedge clk); start = 1'b0; mode = ~md; thresh = ~th;
    cyc = 1;
    while (!fin_m && cyc < 2000) begin @(negedge clk); cyc++; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({fin_sm, en_sm, we_sm, addr_sm, dataW_sm, fin_md, en_md, we_md, addr_md, dataW_md} !== '0) begin
      bad++;
      $display("FAIL reset_outputs sm=%b%b%b %h %h md=%b%b%b %h %h want all 0", fin_sm, en_sm, we_sm,
               addr_sm, dataW_sm, fin_md, en_md, we_md, addr_md, dataW_md);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({fin_sm, en_sm, we_sm, fin_md, en_md, we_md, addr_md, dataW_md} !== '0) begin
        bad++;
        $display("FAIL idle_cycle%0d fin/en/we sm=%b%b%b md=%b%b%b addr=%h dataW=%h want 0", i,
                 fin_sm, en_sm, we_sm, fin_md, en_md, we_md, addr_md, dataW_md);
      end
    end
  endtask

  task automatic test_sobel_small();
    int cyc, p0, v0;
    logic [47:0] o;
    sel = 1'b0;
    for (int i = 0; i < SM_N; i += 2) begin mem[i] = 32'h0; mem[i + 1] = 32'h64646464; end
    exp_q = '{{16'd6, 32'h0}, {16'd7, 32'h0}, {16'd8, 32'hFF000000},
              {16'd9, 32'h000000FF}, {16'd10, 32'h0}, {16'd11, 32'h0}};
    p0 = obs_q.size(); v0 = viol;
    do_run(1'b0, 8'd0, cyc);
    total++;
    if (cyc > bnd(SM_W, SM_H)) begin bad++; $display("FAIL sm_latency got=%0d want<=%0d", cyc, bnd(SM_W, SM_H)); end
    total++;
    if (obs_q.size() - p0 !== exp_q.size()) begin
      bad++; $display("FAIL sm_wcount got=%0d want=%0d", obs_q.size() - p0, exp_q.size());
    end
    foreach (exp_q[i]) begin
      o = (p0 + i < obs_q.size()) ? obs_q[p0 + i] : '0;
      total++;
      if (o !== exp_q[i]) begin bad++; $display("FAIL sm_word%0d got=%h want=%h", i, o, exp_q[i]); end
    end
    total++;
    if (viol !== v0) begin bad++; $display("FAIL sm_range got=%0d want=%0d", viol, v0); end
  endtask

  task automatic test_thresh_small();
    int cyc, p0, th;
    logic [47:0] o;
    sel = 1'b0;
    for (int i = 0; i < SM_N; i += 2) begin mem[i] = 32'h0; mem[i + 1] = 32'h0C0C0C0C; end
    for (int t = 0; t < 2; t++) begin
      th = (t == 0) ? 40 : 49;
      exp_q = '{{16'd6, 32'h0}, {16'd7, 32'h0}, {16'd8, 32'h0},
                {16'd9, 32'h0}, {16'd10, 32'h0}, {16'd11, 32'h0}};
      if (t == 0) begin exp_q[2][31:0] = 32'hFF000000; exp_q[3][31:0] = 32'h000000FF; end
      p0 = obs_q.size();
      do_run(1'b1, 8'(th), cyc);
      total++;
      if (obs_q.size() - p0 !== exp_q.size()) begin
        bad++; $display("FAIL th%0d_wcount got=%0d want=%0d", th, obs_q.size() - p0, exp_q.size());
      end
      foreach (exp_q[i]) begin
        o = (p0 + i < obs_q.size()) ? obs_q[p0 + i] : '0;
        total++;
        if (o !== exp_q[i]) begin bad++; $display("FAIL th%0d_word%0d got=%h want=%h", th, i, o, exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_mid();
    int cyc, p0, v0, th;
    logic [47:0] o;
    sel = 1'b1;
    for (int t = 0; t < 2; t++) begin
      load_random(MD_N);
      th = $urandom_range(20, 250);
      build_exp(MD_W, MD_H, t[0], th);
      p0 = obs_q.size(); v0 = viol;
      do_run(t[0], 8'(th), cyc);
      total++;
      if (cyc > bnd(MD_W, MD_H)) begin bad++; $display("FAIL md%0d_latency got=%0d want<=%0d", t, cyc, bnd(MD_W, MD_H)); end
      total++;
      if (obs_q.size() - p0 !== exp_q.size()) begin
        bad++; $display("FAIL md%0d_wcount got=%0d want=%0d", t, obs_q.size() - p0, exp_q.size());
      end
      foreach (exp_q[i]) begin
        o = (p0 + i < obs_q.size()) ? obs_q[p0 + i] : '0;
        total++;
        if (o !== exp_q[i]) begin bad++; $display("FAIL md%0d_word%0d got=%h want=%h", t, i, o, exp_q[i]); end
      end
      total++;
      if (viol !== v0) begin bad++; $display("FAIL md%0d_range got=%0d want=%0d", t, viol, v0); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, p0, a0;
    logic [47:0] o;
    sel = 1'b1;
    load_random(MD_N);
    build_exp(MD_W, MD_H, 1'b0, 0);
    p0 = obs_q.size();
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (MD_W / 4 + 4 + 50) @(negedge clk);
    total++;
    if (obs_q.size() - p0 <= MD_W / 4) begin
      bad++; $display("FAIL mid_progress got=%0d writes want>%0d", obs_q.size() - p0, MD_W / 4);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({en_m, we_m, fin_m} !== 3'b000) begin bad++; $display("FAIL mid_reset en/we/fin got=%b want=000", {en_m, we_m, fin_m}); end
    a0 = acc_cnt;
    repeat (10) @(negedge clk);
    total++;
    if (acc_cnt !== a0) begin bad++; $display("FAIL no_resume got=%0d accesses want=0", acc_cnt - a0); end
    p0 = obs_q.size();
    do_run(1'b0, 8'd0, cyc);
    total++;
    if (obs_q.size() - p0 !== exp_q.size()) begin
      bad++; $display("FAIL rerun_wcount got=%0d want=%0d", obs_q.size() - p0, exp_q.size());
    end
    foreach (exp_q[i]) begin
      o = (p0 + i < obs_q.size()) ? obs_q[p0 + i] : '0;
      total++;
      if (o !== exp_q[i]) begin bad++; $display("FAIL rerun_word%0d got=%h want=%h", i, o, exp_q[i]); end
    end
  endtask

  task automatic test_start_held();
    int cyc, p0, a0, bf;
    logic [47:0] o;
    sel = 1'b1;
    load_random(MD_N);
    build_exp(MD_W, MD_H, 1'b0, 0);
    for (int run = 0; run < 2; run++) begin
      p0 = obs_q.size();
      if (run == 0) begin
        @(negedge clk); start = 1'b1; mode = 1'b0; thresh = 8'd0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!fin_m && cyc < 2000);
        total++;
        if (cyc > bnd(MD_W, MD_H)) begin bad++; $display("FAIL held_latency got=%0d want<=%0d", cyc, bnd(MD_W, MD_H)); end
        a0 = acc_cnt; bf = 0;
        mode = 1'b1;
        repeat (20) begin @(negedge clk); if (fin_m !== 1'b1) bf++; end
        total++;
        if (bf !== 0) begin bad++; $display("FAIL held_finish got=%0d low cycles want=0", bf); end
        total++;
        if (acc_cnt !== a0) begin bad++; $display("FAIL held_access got=%0d want=0", acc_cnt - a0); end
        start = 1'b0; mode = 1'b0;
        @(negedge clk);
        total++;
        if ({fin_m, en_m} !== 2'b00) begin bad++; $display("FAIL held_to_idle fin/en got=%b want=00", {fin_m, en_m}); end
      end else begin
        do_run(1'b0, 8'd0, cyc);
      end
      total++;
      if (obs_q.size() - p0 !== exp_q.size()) begin
        bad++; $display("FAIL held%0d_wcount got=%0d want=%0d", run, obs_q.size() - p0, exp_q.size());
      end
      foreach (exp_q[i]) begin
        o = (p0 + i < obs_q.size()) ? obs_q[p0 + i] : '0;
        total++;
        if (o !== exp_q[i]) begin bad++; $display("FAIL held%0d_word%0d got=%h want=%h", run, i, o, exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sobel_small();
    test_thresh_small();
    test_random_mid();
    test_reset_midrun();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
